// File: rtl/encoder_conditioner.sv
// Quadrature encoder front end: synchronise, glitch-filter, decode A/B, and
// measure the rising-edge period of filtered A for the divider and stall monitor.
module encoder_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enc_a,
  input  logic              enc_b,
  input  logic [FILT_W-1:0] filter_len,
  input  logic              dir_invert,
  input  logic [31:0]       timeout,
  output logic              out_pulse,
  output logic              out_step,
  output logic              out_dir,
  output logic [31:0]       position,
  output logic [31:0]       period,
  output logic              period_valid,
  output logic              stall,
  output logic [15:0]       quad_err
);

  localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             sync_v;
  logic [1:0]             filt;
  logic [FILT_W-1:0]      cnt [2];
  logic [FILT_W-1:0]      fl_q;
  logic                   fl_chg;
  logic [1:0]             prev;
  logic [1:0]             chg;
  logic                   err;
  logic                   valid;
  logic                   fwd_raw;
  logic                   up;
  logic                   rise_a;
  logic [31:0]            pcnt;
  logic [31:0]            pcnt_inc;
  logic                   armed;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
    end
  end

  // Bit 1 carries channel A, bit 0 channel B throughout.
  assign sync_v = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign fl_chg = (filter_len != fl_q);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      fl_q <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      fl_q <= filter_len;
      for (int i = 0; i < 2; i++) begin
        if (fl_chg || (sync_v[i] == filt[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == filter_len) begin
          filt[i] <= sync_v[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Gray-code decode; forward is 00 -> 10 -> 11 -> 01 -> 00 on {A,B}.
  always_comb begin
    fwd_raw = 1'b0;
    case ({prev, filt})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd_raw = 1'b1;
      default:                            fwd_raw = 1'b0;
    endcase
  end

  assign chg      = filt ^ prev;
  assign err      = &chg;
  assign valid    = ^chg;
  assign up       = fwd_raw ^ dir_invert;
  assign rise_a   = filt[1] & ~prev[1];
  assign pcnt_inc = (&pcnt) ? pcnt : pcnt + 32'd1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev         <= '0;
      out_pulse    <= 1'b0;
      out_step     <= 1'b0;
      out_dir      <= 1'b0;
      position     <= '0;
      quad_err     <= '0;
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      armed        <= 1'b0;
      stall        <= 1'b0;
    end else begin
      prev         <= filt;
      out_pulse    <= filt[1];
      out_step     <= rise_a & valid & up;
      period_valid <= rise_a & armed;
      if (valid) begin
        out_dir  <= up;
        position <= up ? position + 32'd1 : position - 32'd1;
      end
      if (err && (quad_err != 16'hFFFF)) quad_err <= quad_err + 16'd1;
      pcnt <= rise_a ? 32'd0 : pcnt_inc;
      if (rise_a) begin
        armed <= 1'b1;
        if (armed) period <= pcnt_inc;
      end
      if (rise_a || (timeout == 32'd0)) stall <= 1'b0;
      else if (pcnt_inc >= timeout)     stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_encoder_conditioner.sv
// Directed bench for encoder_conditioner: quadrature motion, glitch rejection,
// direction inversion, illegal transitions, stall timing and async reset.
module tb_encoder_conditioner;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        enc_a;
  logic        enc_b;
  logic [15:0] filter_len;
  logic        dir_invert;
  logic [31:0] timeout;
  logic        out_pulse;
  logic        out_step;
  logic        out_dir;
  logic [31:0] position;
  logic [31:0] period;
  logic        period_valid;
  logic        stall;
  logic [15:0] quad_err;

  encoder_conditioner #(.SYNC_STAGES(2), .FILT_W(16)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .enc_a        (enc_a),
    .enc_b        (enc_b),
    .filter_len   (filter_len),
    .dir_invert   (dir_invert),
    .timeout      (timeout),
    .out_pulse    (out_pulse),
    .out_step     (out_step),
    .out_dir      (out_dir),
    .position     (position),
    .period       (period),
    .period_valid (period_valid),
    .stall        (stall),
    .quad_err     (quad_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Event counters sampled mid-cycle, away from the main process sample point.
  int          n_step  = 0;
  int          n_pv    = 0;
  int          n_prise = 0;
  logic [31:0] last_period = '0;
  logic        pulse_q = 1'b0;

  always @(negedge sys_clk) begin
    if (out_step) n_step++;
    if (period_valid) begin
      n_pv++;
      last_period = period;
    end
    if (out_pulse && !pulse_q) n_prise++;
    pulse_q = out_pulse;
  end

  int          tcount = 0;
  int          st_seen;
  int          st_t;
  logic        st_pv;
  logic [31:0] st_per;
  logic        st_stall;
  logic        st_stall_prev;
  logic        stall_prev;

  task automatic tick();
    @(posedge sys_clk);
    #1;
    tcount++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      stall_prev = stall;
      tick();
      if (out_step) begin
        st_seen++;
        st_t          = tcount;
        st_pv         = period_valid;
        st_per        = period;
        st_stall      = stall;
        st_stall_prev = stall_prev;
      end
    end
  endtask

  task automatic drive(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] p0;
  int          s0;
  int          v0;
  int          r0;
  int          lat;
  int          t1;

  initial begin
    rst_n      = 1'b0;
    enc_a      = 1'b0;
    enc_b      = 1'b0;
    filter_len = 16'd3;
    dir_invert = 1'b0;
    timeout    = 32'd0;
    #12;
    check("rst_flags", {27'd0, out_pulse, out_step, out_dir, period_valid, stall}, 32'd0);
    check("rst_position", position, 32'd0);
    check("rst_period", period, 32'd0);
    check("rst_quad_err", {16'd0, quad_err}, 32'd0);
    #10 rst_n = 1'b1;
    hold(5);

    // Clean forward rotation, 100-cycle quarters, 8 full cycles.
    s0 = n_step;
    v0 = n_pv;
    drive(2'b10);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (out_pulse && lat < 0) lat = i;
    end
    // enc_a set just after an edge: the next edge samples it, out_pulse follows 6 edges later.
    check("pulse_latency", 32'(lat - 1), 32'd6);
    drive(2'b11); hold(100);
    drive(2'b01); hold(100);
    drive(2'b00); hold(100);
    for (int c = 0; c < 7; c++) begin
      drive(2'b10); hold(100);
      drive(2'b11); hold(100);
      drive(2'b01); hold(100);
      drive(2'b00); hold(100);
    end
    check("fwd_position", position, 32'd32);
    check("fwd_dir", {31'd0, out_dir}, 32'd1);
    check("fwd_steps", 32'(n_step - s0), 32'd8);
    check("fwd_period_count", 32'(n_pv - v0), 32'd7);
    check("fwd_period", last_period, 32'd400);

    // Glitches of 1..4 cycles rejected with filter_len=4; 5 cycles accepted.
    filter_len = 16'd4;
    hold(5);
    p0 = position;
    r0 = n_prise;
    for (int w = 1; w <= 4; w++) begin
      drive(2'b10); hold(w);
      drive(2'b00); hold(20);
    end
    check("glitch_rise", 32'(n_prise - r0), 32'd0);
    check("glitch_position", position, p0);
    drive(2'b10); hold(5);
    drive(2'b00); hold(20);
    check("pulse5_rise", 32'(n_prise - r0), 32'd1);
    check("pulse5_position", position, p0);
    check("pulse5_dir", {31'd0, out_dir}, 32'd0);

    // Reverse rotation, then the same motion with dir_invert set.
    filter_len = 16'd3;
    hold(5);
    p0 = position;
    s0 = n_step;
    for (int c = 0; c < 2; c++) begin
      drive(2'b01); hold(20);
      drive(2'b11); hold(20);
      drive(2'b10); hold(20);
      drive(2'b00); hold(20);
    end
    check("rev_position", position, p0 - 32'd8);
    check("rev_dir", {31'd0, out_dir}, 32'd0);
    check("rev_steps", 32'(n_step - s0), 32'd0);
    dir_invert = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(2'b01); hold(20);
      drive(2'b11); hold(20);
      drive(2'b10); hold(20);
      drive(2'b00); hold(20);
    end
    check("inv_position", position, p0);
    check("inv_dir", {31'd0, out_dir}, 32'd1);
    check("inv_steps", 32'(n_step - s0), 32'd2);
    dir_invert = 1'b0;

    // Illegal double transitions, then drive quad_err into saturation.
    filter_len = 16'd0;
    hold(5);
    p0 = position;
    drive(2'b11); hold(10);
    drive(2'b00); hold(10);
    drive(2'b11); hold(10);
    check("qerr_three", {16'd0, quad_err}, 32'd3);
    check("qerr_position", position, p0);
    for (int i = 0; i < 65540; i++) begin
      enc_a = ~enc_a;
      enc_b = ~enc_b;
      tick();
    end
    hold(10);
    check("qerr_saturated", {16'd0, quad_err}, 32'h0000FFFF);
    check("qerr_sat_position", position, p0);
    drive(2'b01); hold(20);
    drive(2'b00); hold(20);

    // Stall after 1000 idle cycles, cleared by the next rising A.
    filter_len = 16'd3;
    timeout    = 32'd1000;
    hold(5);
    st_seen = 0;
    drive(2'b10); hold(50);
    check("stall_arm_step", 32'(st_seen), 32'd1);
    t1 = st_t;
    while (!stall && (tcount - t1) < 1500) tick();
    check("stall_latency", 32'(tcount - t1), 32'd1000);
    hold(300);
    drive(2'b11); hold(50);
    drive(2'b01); hold(50);
    drive(2'b00); hold(50);
    st_seen = 0;
    drive(2'b10); hold(50);
    check("restart_step", 32'(st_seen), 32'd1);
    check("restart_stall_before", {31'd0, st_stall_prev}, 32'd1);
    check("restart_stall_cleared", {31'd0, st_stall}, 32'd0);
    check("restart_pv", {31'd0, st_pv}, 32'd1);
    check("restart_period", st_per, 32'(st_t - t1));
    timeout = 32'd0;

    // Asynchronous reset mid-motion, then re-arm of the period measurement.
    drive(2'b11); hold(30);
    drive(2'b01); hold(30);
    @(posedge sys_clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {27'd0, out_pulse, out_step, out_dir, period_valid, stall}, 32'd0);
    check("mid_rst_position", position, 32'd0);
    check("mid_rst_period", period, 32'd0);
    check("mid_rst_quad_err", {16'd0, quad_err}, 32'd0);
    drive(2'b00);
    #20;
    @(negedge sys_clk);
    rst_n = 1'b1;
    hold(5);
    st_seen = 0;
    drive(2'b10); hold(50);
    check("post_rst_first_step", 32'(st_seen), 32'd1);
    check("post_rst_first_pv", {31'd0, st_pv}, 32'd0);
    drive(2'b11); hold(50);
    drive(2'b01); hold(50);
    drive(2'b00); hold(50);
    st_seen = 0;
    drive(2'b10); hold(50);
    check("post_rst_second_pv", {31'd0, st_pv}, 32'd1);
    check("post_rst_period", st_per, 32'd200);
    check("post_rst_position", position, 32'd5);
    check("post_rst_quad_err", {16'd0, quad_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
